fma_norm: RTL and testbench
===========================

Name: fma_norm

Overview:
- Normalization back end for the fused multiply-add datapath.
- Consumes the raw, unnormalized sum mantissa, true exponent and truncation flag produced by the FMA core.
- Returns a hidden-bit-normalized fraction, adjusted exponent and round/sticky bits for the posit encoder.
- Two-stage valid/ready pipeline (leading-zero count, then shift/adjust) with full backpressure and 1 result/cycle throughput.

Parameters:
- TE_BITS, 7, width of the signed total exponent (exponent_t).
- MANT_IN_SIZE, 57, width of the raw add/sub mantissa (1 + 2*28).
- POINT_POS, 54, number of fractional bits in mant_i; value = mant_i * 2^(te_i - POINT_POS).
- FRAC_OUT_SIZE, 14, fraction bits delivered below the hidden one.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept an input beat
- mant_i  in  MANT_IN_SIZE  raw unsigned mantissa magnitude
- te_i  in  TE_BITS  signed total exponent (exponent_t)
- frac_truncated_i  in  1  upstream dropped nonzero bits
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts output beat
- frac_o  out  FRAC_OUT_SIZE  fraction bits below the leading one, MSB-first
- te_o  out  TE_BITS  normalized, saturated exponent
- round_o  out  1  first bit below frac_o
- sticky_o  out  1  OR of all remaining lower bits OR frac_truncated_i
- zero_o  out  1  mant_i was all zeros
- overflow_o  out  1  te_o saturated at +max
- underflow_o  out  1  te_o saturated at -min

Behaviour:
- Reset: synchronous; all stage valid flags cleared; valid_o=0, ready_o=1; frac_o, te_o, round_o, sticky_o, zero_o, overflow_o, underflow_o all 0.
- Reset mid-operation: in-flight beats are discarded and never emitted.
- Handshake:
  - Input transfer occurs on valid_i && ready_o; output transfer occurs on valid_o && ready_i.
  - Stage k advances when it is empty or stage k+1 advances in the same cycle.
  - ready_o = !s1_valid || s1_advance. It is combinational from ready_i and must not depend on valid_i.
  - Output registers hold stable while valid_o && !ready_i.
- Latency: exactly 2 cycles from input transfer to valid_o with no stall; back-to-back throughput 1/cycle; no bubble is inserted when the pipe is full and ready_i=1.
- Stage 1 registers mant_i, te_i, frac_truncated_i, lzc = leading-zero count of mant_i (0..MANT_IN_SIZE), and zero = (mant_i==0).
- Stage 2:
  - msb = MANT_IN_SIZE-1-lzc; shifted = mant_i << lzc (leading one at MSB).
  - frac_o = shifted[MSB-1 -: FRAC_OUT_SIZE]; round_o = next bit down.
  - sticky_o = OR(remaining lower bits) | frac_truncated_i.
  - Exponent computed at width TE_BITS+$clog2(MANT_IN_SIZE)+2 signed: e = te_i + msb - POINT_POS.
- Saturation (TE_BITS=7 gives range -64..63):
  - e > max: te_o=max, overflow_o=1.
  - e < min: te_o=min, underflow_o=1.
  - Otherwise both flags are 0.
- Zero input: zero_o=1, frac_o=0, te_o=0, round_o=0, sticky_o=frac_truncated_i, overflow_o=0, underflow_o=0.
- If fewer than FRAC_OUT_SIZE+1 bits lie below the leading one, the missing low bits are filled with 0.
- Simultaneous input accept and output drain with a full pipe: both transfers occur; no beat is lost or duplicated.

Test Plan:
- mant_i=1<<54, te_i=0, frac_truncated_i=0 -> after 2 cycles: te_o=0, frac_o=0, round_o=0, sticky_o=0, zero_o=0.
- mant_i=3<<54, te_i=5 -> te_o=6, frac_o=14'h2000, round_o=0, sticky_o=0.
- mant_i=(1<<54)|(1<<39) -> round_o=1, sticky_o=0. The same stimulus plus bit 0 set -> round_o=1, sticky_o=1. mant_i=1<<54 with frac_truncated_i=1 -> sticky_o=1.
- Exponent saturation:
  - mant_i=1, te_i=10 -> te_o=-44, no flags.
  - mant_i=1, te_i=-20 -> te_o=-64, underflow_o=1.
  - mant_i=1<<56, te_i=62 -> te_o=63, overflow_o=1.
- mant_i=0, te_i=17 -> zero_o=1, te_o=0, frac_o=0.
- Handshake stress:
  - Stream 8 beats back-to-back with ready_i held low for cycles 3-6 -> ready_o drops within the same cycle once both stages are full; all 8 results emerge in order, unchanged while stalled.
  - Assert rst_i mid-stream -> valid_o=0 next cycle and no stale beat is emitted afterwards.

Source files
------------

// File: rtl/fma_norm.sv
// Normalization back end for the fused multiply-add datapath.
// Takes the raw unnormalized sum mantissa, its true exponent and an upstream
// truncation flag, and returns a hidden-bit-normalized fraction, a saturated
// exponent and round/sticky bits for the posit encoder.
//
// Two-stage valid/ready pipeline: stage 1 registers the input beat together
// with its leading-zero count; stage 2 shifts, adjusts and saturates.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i / ready_o       input handshake
//   mant_i, te_i            raw mantissa magnitude, signed total exponent
//   frac_truncated_i        upstream dropped nonzero bits
//   valid_o / ready_i       output handshake
//   frac_o, te_o            fraction below the leading one, saturated exponent
//   round_o, sticky_o       first bit below frac_o, OR of everything lower
//   zero_o                  mantissa was zero
//   overflow_o/underflow_o  te_o saturated at +max / -min
module fma_norm #(
    parameter int unsigned TE_BITS       = 7,
    parameter int unsigned MANT_IN_SIZE  = 57,
    parameter int unsigned POINT_POS     = 54,
    parameter int unsigned FRAC_OUT_SIZE = 14
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [MANT_IN_SIZE-1:0]  mant_i,
    input  logic [TE_BITS-1:0]       te_i,
    input  logic                     frac_truncated_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [FRAC_OUT_SIZE-1:0] frac_o,
    output logic [TE_BITS-1:0]       te_o,
    output logic                     round_o,
    output logic                     sticky_o,
    output logic                     zero_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned LzcW = $clog2(MANT_IN_SIZE + 1);
    localparam int unsigned EW   = TE_BITS + $clog2(MANT_IN_SIZE) + 2;
    // Bits left below the round bit once the leading one sits at the MSB.
    localparam int unsigned LowW = MANT_IN_SIZE - 2 - FRAC_OUT_SIZE;

    localparam logic signed [EW-1:0] EMax = EW'((1 << (TE_BITS - 1)) - 1);
    localparam logic signed [EW-1:0] EMin = EW'(-(1 << (TE_BITS - 1)));

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_advance, s2_advance;

    assign s2_advance = !s2_valid_q || ready_i;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign ready_o    = !s1_valid_q || s1_advance;

    // Stage 1 state
    logic [MANT_IN_SIZE-1:0] s1_mant_q, s1_mant_d;
    logic [TE_BITS-1:0]      s1_te_q, s1_te_d;
    logic                    s1_trunc_q, s1_trunc_d;
    logic [LzcW-1:0]         s1_lzc_q, s1_lzc_d;
    logic                    s1_zero_q, s1_zero_d;
    logic [LzcW-1:0]         lzc;

    // Stage 2 (output) state
    logic [FRAC_OUT_SIZE-1:0] frac_q, frac_d;
    logic [TE_BITS-1:0]       te_q, te_d;
    logic                     round_q, round_d;
    logic                     sticky_q, sticky_d;
    logic                     zero_q, zero_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        lzc = LzcW'(MANT_IN_SIZE);
        for (int i = 0; i < int'(MANT_IN_SIZE); i++) begin
            if (mant_i[i]) lzc = LzcW'(int'(MANT_IN_SIZE) - 1 - i);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_te_d    = s1_te_q;
        s1_trunc_d = s1_trunc_q;
        s1_lzc_d   = s1_lzc_q;
        s1_zero_d  = s1_zero_q;
        if (ready_o) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_mant_d  = mant_i;
                s1_te_d    = te_i;
                s1_trunc_d = frac_truncated_i;
                s1_lzc_d   = lzc;
                s1_zero_d  = (mant_i == '0);
            end
        end
    end

    logic [MANT_IN_SIZE-1:0] shifted;
    logic signed [EW-1:0]    te_ext, lzc_ext, e;

    always_comb begin
        // Shift-in zeros fill any missing low fraction/round bits.
        shifted = s1_mant_q << s1_lzc_q;
        te_ext  = {{(EW - TE_BITS){s1_te_q[TE_BITS-1]}}, s1_te_q};
        lzc_ext = {{(EW - LzcW){1'b0}}, s1_lzc_q};
        // e = te + msb - POINT_POS, with msb = MANT_IN_SIZE-1-lzc
        e = te_ext + $signed(EW'(MANT_IN_SIZE - 1)) - lzc_ext - $signed(EW'(POINT_POS));

        s2_valid_d = s2_valid_q;
        frac_d     = frac_q;
        te_d       = te_q;
        round_d    = round_q;
        sticky_d   = sticky_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                frac_d   = shifted[MANT_IN_SIZE-2 -: FRAC_OUT_SIZE];
                round_d  = shifted[LowW];
                sticky_d = (|shifted[LowW-1:0]) | s1_trunc_q;
                zero_d   = s1_zero_q;
                ovf_d    = 1'b0;
                unf_d    = 1'b0;
                if (s1_zero_q) begin
                    frac_d  = '0;
                    te_d    = '0;
                    round_d = 1'b0;
                end else if (e > EMax) begin
                    te_d  = EMax[TE_BITS-1:0];
                    ovf_d = 1'b1;
                end else if (e < EMin) begin
                    te_d  = EMin[TE_BITS-1:0];
                    unf_d = 1'b1;
                end else begin
                    te_d = e[TE_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_te_q    <= '0;
            s1_trunc_q <= 1'b0;
            s1_lzc_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            frac_q     <= '0;
            te_q       <= '0;
            round_q    <= 1'b0;
            sticky_q   <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_te_q    <= s1_te_d;
            s1_trunc_q <= s1_trunc_d;
            s1_lzc_q   <= s1_lzc_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            frac_q     <= frac_d;
            te_q       <= te_d;
            round_q    <= round_d;
            sticky_q   <= sticky_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign valid_o     = s2_valid_q;
    assign frac_o      = frac_q;
    assign te_o        = te_q;
    assign round_o     = round_q;
    assign sticky_o    = sticky_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_fma_norm.sv
// Scoreboard bench for fma_norm: a driver pushes hand-computed expectations
// as beats are accepted; an independent monitor pops and compares whenever an
// output beat transfers, and checks that stalled outputs hold steady.
module tb_fma_norm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [56:0] mant_i;
    logic [6:0]  te_i;
    logic        frac_truncated_i;
    logic        valid_o;
    logic        ready_i;
    logic [13:0] frac_o;
    logic [6:0]  te_o;
    logic        round_o, sticky_o, zero_o, overflow_o, underflow_o;

    fma_norm dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .mant_i           (mant_i),
        .te_i             (te_i),
        .frac_truncated_i (frac_truncated_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .frac_o           (frac_o),
        .te_o             (te_o),
        .round_o          (round_o),
        .sticky_o         (sticky_o),
        .zero_o           (zero_o),
        .overflow_o       (overflow_o),
        .underflow_o      (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [56:0] mant;
        logic [6:0]  te;
        logic        trunc;
        logic [13:0] frac;
        logic [6:0]  te_e;
        logic        rnd, stk, zero, ovf, unf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   beat_no  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [56:0] mant, input int te, input logic trunc,
                                input logic [13:0] frac, input int te_e, input logic rnd,
                                input logic stk, input logic zero, input logic ovf,
                                input logic unf);
        vec_t v;
        v.mant = mant; v.te = 7'(te); v.trunc = trunc; v.frac = frac; v.te_e = 7'(te_e);
        v.rnd = rnd; v.stk = stk; v.zero = zero; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // Drive one beat starting at a negedge; return at the negedge after acceptance.
    task automatic send(input vec_t v);
        int n = 0;
        mant_i = v.mant; te_i = v.te; frac_truncated_i = v.trunc; valid_i = 1'b1;
        #1;
        while (!ready_o && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        if (!ready_o) chk("send_timeout", 64'(ready_o), 64'd1);
        else sb.push_back(v);
        @(negedge clk_i);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_i); n++;
        end
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor
    logic        stall_prev = 1'b0;
    logic [13:0] h_frac;
    logic [6:0]  h_te;
    logic [4:0]  h_flags;

    always begin
        @(negedge clk_i);
        #1;
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_valid", 64'(valid_o), 64'd1);
                chk("stall_hold_frac", 64'(frac_o), 64'(h_frac));
                chk("stall_hold_te", 64'(te_o), 64'(h_te));
                chk("stall_hold_flags",
                    64'({round_o, sticky_o, zero_o, overflow_o, underflow_o}), 64'(h_flags));
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(valid_o), 64'd0);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk($sformatf("beat%0d frac", beat_no), 64'(frac_o), 64'(e.frac));
                    chk($sformatf("beat%0d te", beat_no), 64'(te_o), 64'(e.te_e));
                    chk($sformatf("beat%0d round", beat_no), 64'(round_o), 64'(e.rnd));
                    chk($sformatf("beat%0d sticky", beat_no), 64'(sticky_o), 64'(e.stk));
                    chk($sformatf("beat%0d zero", beat_no), 64'(zero_o), 64'(e.zero));
                    chk($sformatf("beat%0d ovf", beat_no), 64'(overflow_o), 64'(e.ovf));
                    chk($sformatf("beat%0d unf", beat_no), 64'(underflow_o), 64'(e.unf));
                    beat_no++;
                end
            end
            stall_prev = valid_o && !ready_i;
            h_frac  = frac_o;
            h_te    = te_o;
            h_flags = {round_o, sticky_o, zero_o, overflow_o, underflow_o};
        end
    end

    initial begin
        logic [56:0] one = 57'd1;
        //          mant                          te  tr frac      te_e rnd stk zero ovf unf
        vecs.push_back(mk(one << 54,               0, 0, 14'h0000,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(57'd3 << 54,             5, 0, 14'h2000,   6, 0, 0, 0, 0, 0));
        vecs.push_back(mk((one << 54) | (one << 39), 0, 0, 14'h0000, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk((one << 54) | (one << 39) | one, 0, 0, 14'h0000, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(one << 54,               0, 1, 14'h0000,   0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(one,                    10, 0, 14'h0000, -44, 0, 0, 0, 0, 0));
        vecs.push_back(mk(one,                   -20, 0, 14'h0000, -64, 0, 0, 0, 0, 1));
        vecs.push_back(mk(one << 56,              62, 0, 14'h0000,  63, 0, 0, 0, 1, 0));
        vecs.push_back(mk(57'd0,                  17, 0, 14'h0000,   0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(57'd0,                  17, 1, 14'h0000,   0, 0, 1, 1, 0, 0));
        vecs.push_back(mk({57{1'b1}},              0, 0, 14'h3FFF,   2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(57'h25,                  0, 0, 14'h0A00, -49, 0, 0, 0, 0, 0));
        vecs.push_back(mk(one << 54,              63, 0, 14'h0000,  63, 0, 0, 0, 0, 0));
        vecs.push_back(mk(one << 54,             -64, 0, 14'h0000, -64, 0, 0, 0, 0, 0));
        vecs.push_back(mk(one << 53,             -64, 0, 14'h0000, -64, 0, 0, 0, 0, 1));
        vecs.push_back(mk(one << 55,              -3, 0, 14'h0000,  -2, 0, 0, 0, 0, 0));

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        mant_i = '0; te_i = '0; frac_truncated_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("reset valid_o", 64'(valid_o), 64'd0);
        chk("reset ready_o", 64'(ready_o), 64'd1);
        chk("reset data", 64'({frac_o, te_o, round_o, sticky_o, zero_o, overflow_o,
                               underflow_o}), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Latency: accepted at edge T0, visible after edge T0+1.
        send(vecs[0]);
        valid_i = 1'b0;
        #1 chk("latency after 1 edge", 64'(valid_o), 64'd0);
        @(negedge clk_i);
        #1 chk("latency after 2 edges", 64'(valid_o), 64'd1);
        @(negedge clk_i);
        drain();

        // All directed vectors back-to-back.
        foreach (vecs[i]) send(vecs[i]);
        valid_i = 1'b0;
        drain();

        // 8 beats streamed while the output stalls for 4 cycles.
        fork
            begin
                for (int i = 0; i < 8; i++) send(vecs[i + 1]);
                valid_i = 1'b0;
            end
            begin
                ready_i = 1'b1;
                repeat (3) @(negedge clk_i);
                ready_i = 1'b0;
                repeat (3) @(negedge clk_i);
                #1 chk("ready_o low when full", 64'(ready_o), 64'd0);
                @(negedge clk_i);
                ready_i = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight: they must vanish.
        ready_i = 1'b0;
        send(vecs[2]);
        send(vecs[3]);
        valid_i = 1'b0;
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk_i);
        #1;
        chk("mid reset valid_o", 64'(valid_o), 64'd0);
        chk("mid reset ready_o", 64'(ready_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        ready_i = 1'b1;
        repeat (10) @(negedge clk_i);
        #1 chk("no stale beat", 64'(valid_o), 64'd0);
        @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
